// File: rtl/oneshot_sched_pkg.sv
// oneshot_sched_pkg: shared types and helpers for the one-shot pipe scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: scheduler state enum, round-robin pick returning a one-hot grant,
// and a one-hot to index encoder. Functions work on MAX_REQ-wide vectors so
// one definition serves every legal NREQ (2..16).
package oneshot_sched_pkg;

  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FLIGHT = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // First set bit of req scanning upward from ptr, wrapping at nreq.
  // ptr must be < nreq; bits at or above nreq are ignored.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [MAX_IDW-1:0] ptr,
                                                 input int nreq);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < nreq) begin
        idx = int'(ptr) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx[MAX_IDW-1:0]]) begin
          gnt[idx[MAX_IDW-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic logic [MAX_IDW-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = MAX_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/oneshot_delay_line.sv
// oneshot_delay_line: plain DEPTH-stage shift register carrying the epoch token.
// Latency: d to q is DEPTH cycles.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst (sync, active-high), d (stage-0 input), q (tail, stage DEPTH-1).
module oneshot_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= {stage_q[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/oneshot_pipe_sched.sv
// oneshot_pipe_sched: round-robin scheduler granting one injection per epoch
//   into a shared single-shot delay line, then locking out until re-armed.
// Latency: req sampled at edge t -> gnt/pipe_in cycle t+1 -> pipe_out cycle
//   t+1+DEPTH -> done from cycle t+2+DEPTH.
// Backpressure: none queued; losing requesters must hold req for a later epoch,
//   and req is ignored entirely outside ARMED.
// Ports: clk, rst (sync, active-high); req_i[NREQ] level requests; rearm_i
//   epoch re-open pulse (DONE only); gnt_o one-hot grant pulse; winner_o last
//   granted index; pipe_in_o / pipe_out_o delay-line head / tail; busy_o
//   (ISSUE, FLIGHT); done_o (DONE).
// Optional: define ONESHOT_SCHED_SVA_EN to compile embedded assertions and the
//   rearm pulse assumption; behaviour is identical either way.
module oneshot_pipe_sched
  import oneshot_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 3,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            rearm_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  winner_o,
  output logic            pipe_in_o,
  output logic            pipe_out_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CNTW = $clog2(DEPTH + 1);

  sched_state_e       state_q;
  logic [NREQ-1:0]    gnt_q;
  logic [IDW-1:0]     winner_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic               pipe_in_q;
  logic               busy_q;
  logic               done_q;
  logic [CNTW-1:0]    cnt_q;

  logic [MAX_REQ-1:0] pick_full;
  logic [NREQ-1:0]    pick_oh_d;
  logic [IDW-1:0]     pick_idx_d;
  logic [IDW-1:0]     rr_ptr_d;

  // Candidate grant, only consumed when ARMED sees a request.
  always_comb begin
    pick_full  = rr_pick(MAX_REQ'(req_i), MAX_IDW'(rr_ptr_q), NREQ);
    pick_oh_d  = pick_full[NREQ-1:0];
    pick_idx_d = IDW'(onehot_idx(pick_full));
    rr_ptr_d   = (pick_idx_d == IDW'(NREQ - 1)) ? '0 : pick_idx_d + IDW'(1);
  end

  // All outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARMED;
      gnt_q     <= '0;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      pipe_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (|req_i) begin
            state_q   <= ST_ISSUE;
            gnt_q     <= pick_oh_d;
            winner_q  <= pick_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            pipe_in_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q   <= ST_FLIGHT;
          gnt_q     <= '0;
          pipe_in_q <= 1'b0;
          cnt_q     <= '0;
        end
        ST_FLIGHT: begin
          // cnt reaches DEPTH-1 in the cycle the token sits at the tail.
          if (cnt_q == CNTW'(DEPTH - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        ST_DONE: begin
          if (rearm_i) begin
            state_q <= ST_ARMED;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  oneshot_delay_line #(
    .DEPTH (DEPTH)
  ) u_delay_line (
    .clk (clk),
    .rst (rst),
    .d   (pipe_in_q),
    .q   (pipe_out_o)
  );

  assign gnt_o     = gnt_q;
  assign winner_o  = winner_q;
  assign pipe_in_o = pipe_in_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

`ifdef ONESHOT_SCHED_SVA_EN
  // Remembers that this epoch's token already left the tail.
  logic fired_q;
  always_ff @(posedge clk) begin
    if (rst)                                fired_q <= 1'b0;
    else if (pipe_out_o)                    fired_q <= 1'b1;
    else if (rearm_i && state_q == ST_DONE) fired_q <= 1'b0;
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));
  a_single_pulse: assert property (@(posedge clk) disable iff (rst)
    pipe_out_o |-> !fired_q);
  a_gnt_to_out: assert property (@(posedge clk) disable iff (rst)
    (gnt_q != '0) |-> ##DEPTH pipe_out_o);
  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done_q |-> !busy_q);
  m_rearm_pulse: assume property (@(posedge clk) disable iff (rst)
    rearm_i |=> !rearm_i);
`endif

endmodule

// File: tb/tb_oneshot_pipe_sched.sv
// tb_oneshot_pipe_sched: directed bench for oneshot_pipe_sched (NREQ=4, DEPTH=3).
// An epoch-timestamp model predicts every output each cycle; directed steps
// add hand-computed literal expectations.
module tb_oneshot_pipe_sched;

  localparam int NREQ  = 4;
  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       rearm_i;
  logic [3:0] gnt_o;
  logic [1:0] winner_o;
  logic       pipe_in_o, pipe_out_o, busy_o, done_o;

  oneshot_pipe_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .rearm_i    (rearm_i),
    .gnt_o      (gnt_o),
    .winner_o   (winner_o),
    .pipe_in_o  (pipe_in_o),
    .pipe_out_o (pipe_out_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: epochs described by their grant edge ----------------
  int   e = 0;             // number of rising edges seen
  bit   chk_en = 1'b0;
  bit   m_armed, m_active, m_done;
  int   m_t, m_rr, m_win;
  logic [3:0] x_gnt;
  logic [1:0] x_win;
  logic       x_pin, x_pout, x_busy, x_done;

  initial begin
    m_armed = 1'b0; m_active = 1'b0; m_done = 1'b0;
    m_t = 0; m_rr = 0; m_win = 0;
    forever begin
      @(posedge clk);
      e++;
      if (rst) begin
        m_armed = 1'b1; m_active = 1'b0; m_done = 1'b0;
        m_rr = 0; m_win = 0;
        chk_en = 1'b1;
      end else if (m_armed && (req_i != 4'b0)) begin
        for (int i = NREQ - 1; i >= 0; i--) begin
          if (req_i[(m_rr + i) % NREQ]) m_win = (m_rr + i) % NREQ;
        end
        m_rr     = (m_win + 1) % NREQ;
        m_t      = e;
        m_armed  = 1'b0;
        m_active = 1'b1;
      end else if (m_done && rearm_i) begin
        m_done  = 1'b0;
        m_armed = 1'b1;
      end else if (m_active && e == m_t + 1 + DEPTH) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
      // Expected outputs for the cycle following this edge.
      x_gnt  = (m_active && e == m_t) ? (4'b0001 << m_win) : 4'b0000;
      x_pin  = m_active && (e == m_t);
      x_pout = m_active && (e == m_t + DEPTH);
      x_busy = m_active;
      x_done = m_done;
      x_win  = 2'(m_win);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_gnt",      32'(gnt_o),      32'(x_gnt));
        chk("cyc_winner",   32'(winner_o),   32'(x_win));
        chk("cyc_pipe_in",  32'(pipe_in_o),  32'(x_pin));
        chk("cyc_pipe_out", 32'(pipe_out_o), 32'(x_pout));
        chk("cyc_busy",     32'(busy_o),     32'(x_busy));
        chk("cyc_done",     32'(done_o),     32'(x_done));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_gnt(input string nm);
    int k = 0;
    while (gnt_o == 4'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(gnt_o != 4'b0), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(done_o), 32'd1);
  endtask

  task automatic pulse_rearm();
    rearm_i = 1'b1;
    @(negedge clk);
    rearm_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},  32'(gnt_o),      32'd0);
    chk({nm, "_win"},  32'(winner_o),   32'd0);
    chk({nm, "_pin"},  32'(pipe_in_o),  32'd0);
    chk({nm, "_pout"}, 32'(pipe_out_o), 32'd0);
    chk({nm, "_busy"}, 32'(busy_o),     32'd0);
    chk({nm, "_done"}, 32'(done_o),     32'd0);
  endtask

  initial begin
    int pulses, grants;
    rst = 1'b1; req_i = 4'b0; rearm_i = 1'b0;

    // Reset state (edges 1 and 2 in reset).
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request sampled at edge 5.
    req_i = 4'b0010;
    @(negedge clk);                                   // cycle 6
    chk("t1_edge",   32'(e), 32'd5);
    chk("t1_gnt",    32'(gnt_o), 32'h2);
    chk("t1_pin",    32'(pipe_in_o), 32'd1);
    chk("t1_winner", 32'(winner_o), 32'd1);
    chk("t1_busy",   32'(busy_o), 32'd1);
    req_i = 4'b0;
    repeat (2) @(negedge clk);                        // cycle 8
    chk("t1_pout_c8", 32'(pipe_out_o), 32'd0);
    @(negedge clk);                                   // cycle 9
    chk("t1_pout_c9", 32'(pipe_out_o), 32'd1);
    chk("t1_done_c9", 32'(done_o), 32'd0);
    @(negedge clk);                                   // cycle 10
    chk("t1_done_c10", 32'(done_o), 32'd1);
    chk("t1_busy_c10", 32'(busy_o), 32'd0);
    chk("t1_pout_c10", 32'(pipe_out_o), 32'd0);

    // Lockout: requests held in DONE without rearm.
    req_i = 4'b1111;
    pulses = 0; grants = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pipe_out_o) pulses++;
      if (gnt_o != 4'b0) grants++;
    end
    chk("lock_grants", 32'(grants), 32'd0);
    chk("lock_pulses", 32'(pulses), 32'd0);
    chk("lock_done",   32'(done_o), 32'd1);
    chk("lock_winner", 32'(winner_o), 32'd1);

    // Round-robin under full contention, starting from a fresh pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst2");
    wait_gnt("rr0_wait");
    chk("rr0_gnt", 32'(gnt_o), 32'h1);
    wait_done("rr0_done");
    pulse_rearm();
    wait_gnt("rr1_wait");
    chk("rr1_gnt", 32'(gnt_o), 32'h2);
    wait_done("rr1_done");
    pulse_rearm();
    wait_gnt("rr2_wait");
    chk("rr2_gnt", 32'(gnt_o), 32'h4);
    chk("rr2_winner", 32'(winner_o), 32'd2);
    wait_done("rr2_done");
    req_i = 4'b0;

    // Illegal rearm during FLIGHT (pointer now 3, so bit 0 wins after wrap).
    pulse_rearm();
    req_i = 4'b0001;
    wait_gnt("ill_wait");
    chk("ill_gnt", 32'(gnt_o), 32'h1);
    req_i = 4'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rearm_i = (i == 0);
      if (pipe_out_o) pulses++;
    end
    rearm_i = 1'b0;
    chk("ill_pulses", 32'(pulses), 32'd1);
    chk("ill_done",   32'(done_o), 32'd1);

    // Reset in cycle t+2, while the token is in flight.
    pulse_rearm();
    req_i = 4'b0010;
    wait_gnt("mid_wait");
    chk("mid_gnt", 32'(gnt_o), 32'h2);
    req_i = 4'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("mid");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pipe_out_o) pulses++;
    end
    chk("mid_pulses", 32'(pulses), 32'd0);

    // One epoch from the reset pointer, then rearm and req together in DONE.
    req_i = 4'b0001;
    wait_gnt("sim_wait");
    chk("sim_gnt0", 32'(gnt_o), 32'h1);
    req_i = 4'b0;
    wait_done("sim_done");
    rearm_i = 1'b1;
    req_i   = 4'b0100;
    @(negedge clk);
    rearm_i = 1'b0;
    chk("sim_armed_gnt",  32'(gnt_o),  32'd0);
    chk("sim_armed_done", 32'(done_o), 32'd0);
    chk("sim_armed_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("sim_gnt1",    32'(gnt_o), 32'h4);
    chk("sim_winner1", 32'(winner_o), 32'd2);
    req_i = 4'b0;
    wait_done("sim_done2");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
